select_biggest_way: RTL and testbench
=====================================

// Module: select_biggest_way
// PURPOSE
//  Unsigned max-select across NUM_WAY packed ways, with a per-way enable mask.
//  Returns the largest value among the ways whose condition bit is set, plus that way's index and a found flag.
//  Used as a priority/victim picker in advanced_logic (e.g. a counter/age compare).
//  Comparison is a combinational reduction tree; all outputs are registered, so latency is 1 cycle.
// PARAMETERS
//  SINGLE_WAY_WIDTH_IN_BITS  4   width of each way value, unsigned
//  NUM_WAY                   16  number of ways (>=2, any integer; non-power-of-2 allowed)
//  INDEX_WIDTH               $clog2(NUM_WAY)  width of select_index_out (derived, do not override)
// PORTS
//  clk_in            in   1                                  single clock, rising edge
//  reset_in          in   1                                  asynchronous, active-low reset
//  way_flatted_in    in   SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY   way i = bits [i*W +: W]; way 0 in the LSBs
//  condition_in      in   NUM_WAY                            bit i = 1 -> way i takes part in the compare
//  select_out        out  SINGLE_WAY_WIDTH_IN_BITS           biggest enabled way value
//  select_index_out  out  INDEX_WIDTH                        index of the way that supplied select_out
//  select_valid_out  out  1                                  1 if at least one condition_in bit was set
// BEHAVIOUR
//  - Reset (reset_in=0, asynchronous): select_out=0, select_index_out=0, select_valid_out=0; held while low.
//  - Each rising clk_in edge (reset_in=1) registers the result for the current inputs.
//    Outputs reflect the inputs sampled one edge earlier; no handshake; a new input is accepted every cycle.
//  - Compare rule:
//    - Only ways with condition_in[i]=1 take part; the compare is unsigned over the full W bits.
//    - select_out = max over enabled ways.
//  - Tie-break: equal maxima -> the lowest index wins in select_index_out (select_out is the same either way).
//  - No enabled way (condition_in == 0):
//    - select_valid_out=0, select_out=0, select_index_out=0.
//    - A disabled way never wins, even if its value is larger.
//  - Enabled way with value 0 is still valid: select_valid_out=1, select_out=0, select_index_out=that index.
//  - Implementation: balanced pairwise tree of ceil(log2 NUM_WAY) levels.
//    - Each node carries {valid, value, index}.
//    - A node passes the valid child if only one is valid; with both valid it takes the larger value, lower index on a tie.
//    - An odd leftover way passes straight to the next level.
//  - No internal state beyond the output registers; outputs are deterministic after reset.
// TESTING
//  - Reset: assert reset_in low mid-run -> all outputs 0 immediately; they stay 0 until the first edge after release.
//  - Masked max, NUM_WAY=16, W=4:
//    - Ways 15..0 = {a,b,c,d,5,2,3,4,5,2,3,4,a,b,a,5}, condition=16'b1110_0111_1110_0111.
//    - Next edge -> select_out=4'hc, select_index_out=13, valid=1. Way 12 (d) is masked.
//  - Masked max, NUM_WAY=16, W=4:
//    - Ways 15..0 = {5,8,7,c,2,9,3,4,2,9,3,4,5,8,7,a}, condition=16'b1011_0111_1111_1111.
//    - Next edge -> select_out=4'hc, select_index_out=12, valid=1.
//  - Tie: all ways = 4'h7, condition=16'hFFFF -> select_out=7, select_index_out=0.
//    - Then condition=16'hFFF0 -> select_index_out=4.
//  - Empty mask: any data, condition=0 -> select_out=0, select_index_out=0, select_valid_out=0.
//  - Streaming: change inputs every cycle for 20 random vectors.
//    - Each output must equal a reference max of the vector from the previous cycle; also check the extreme values F and 0.

Source files
------------

// File: rtl/select_biggest_way.sv
// Registered unsigned max-select over NUM_WAY packed ways with a per-way enable mask.
// A balanced pairwise tree finds the largest enabled value and its lowest index.
`timescale 1ns/1ps

module select_biggest_way #(
    parameter int unsigned SINGLE_WAY_WIDTH_IN_BITS = 4,
    parameter int unsigned NUM_WAY = 16,
    localparam int unsigned INDEX_WIDTH = $clog2(NUM_WAY)
) (
    input  logic                                        clk_in,
    input  logic                                        reset_in,
    input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] way_flatted_in,
    input  logic [NUM_WAY-1:0]                          condition_in,
    output logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]         select_out,
    output logic [INDEX_WIDTH-1:0]                      select_index_out,
    output logic                                        select_valid_out
);

    localparam int unsigned W = SINGLE_WAY_WIDTH_IN_BITS;
    localparam int unsigned Levels = $clog2(NUM_WAY);
    // One spare slot so the right-child index of an odd tail never leaves the array.
    localparam int unsigned Slots = NUM_WAY + 1;

    logic                   node_valid [Levels+1][Slots];
    logic [W-1:0]           node_value [Levels+1][Slots];
    logic [INDEX_WIDTH-1:0] node_index [Levels+1][Slots];

    logic [W-1:0]           sel_value_d, sel_value_q;
    logic [INDEX_WIDTH-1:0] sel_index_d, sel_index_q;
    logic                   sel_valid_d, sel_valid_q;

    always_comb begin
        int n;
        logic take_right;
        for (int l = 0; l <= int'(Levels); l++) begin
            for (int i = 0; i < int'(Slots); i++) begin
                node_valid[l][i] = 1'b0;
                node_value[l][i] = '0;
                node_index[l][i] = '0;
            end
        end
        for (int i = 0; i < int'(NUM_WAY); i++) begin
            node_valid[0][i] = condition_in[i];
            node_value[0][i] = condition_in[i] ? way_flatted_in[i*W +: W] : '0;
            node_index[0][i] = INDEX_WIDTH'(i);
        end
        n = int'(NUM_WAY);
        take_right = 1'b0;
        for (int l = 1; l <= int'(Levels); l++) begin
            for (int i = 0; i < int'(NUM_WAY + 1) / 2; i++) begin
                if (2 * i + 1 < n) begin
                    // Right wins only when strictly larger, so ties keep the lower index.
                    take_right = node_valid[l-1][2*i+1] &&
                                 (!node_valid[l-1][2*i] ||
                                  (node_value[l-1][2*i+1] > node_value[l-1][2*i]));
                    node_valid[l][i] = node_valid[l-1][2*i] | node_valid[l-1][2*i+1];
                    node_value[l][i] = take_right ? node_value[l-1][2*i+1]
                                                  : node_value[l-1][2*i];
                    node_index[l][i] = take_right ? node_index[l-1][2*i+1]
                                                  : node_index[l-1][2*i];
                end else if (2 * i < n) begin
                    node_valid[l][i] = node_valid[l-1][2*i];
                    node_value[l][i] = node_value[l-1][2*i];
                    node_index[l][i] = node_index[l-1][2*i];
                end
            end
            n = (n + 1) / 2;
        end
        sel_valid_d = node_valid[Levels][0];
        sel_value_d = sel_valid_d ? node_value[Levels][0] : '0;
        sel_index_d = sel_valid_d ? node_index[Levels][0] : '0;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            sel_value_q <= '0;
            sel_index_q <= '0;
            sel_valid_q <= 1'b0;
        end else begin
            sel_value_q <= sel_value_d;
            sel_index_q <= sel_index_d;
            sel_valid_q <= sel_valid_d;
        end
    end

    assign select_out       = sel_value_q;
    assign select_index_out = sel_index_q;
    assign select_valid_out = sel_valid_q;

endmodule

// File: tb/tb_select_biggest_way.sv
// Directed self-checking bench for select_biggest_way (NUM_WAY=16, W=4).
`timescale 1ns/1ps

module tb_select_biggest_way;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic [63:0] way_flatted_in = '0;
    logic [15:0] condition_in = '0;
    logic [3:0]  select_out;
    logic [3:0]  select_index_out;
    logic        select_valid_out;

    int errors = 0;
    int checks = 0;

    select_biggest_way #(
        .SINGLE_WAY_WIDTH_IN_BITS(4),
        .NUM_WAY(16)
    ) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .way_flatted_in  (way_flatted_in),
        .condition_in    (condition_in),
        .select_out      (select_out),
        .select_index_out(select_index_out),
        .select_valid_out(select_valid_out)
    );

    always #5 clk_in = ~clk_in;

    // Linear scan reference: strictly-greater update keeps the lowest index on ties.
    function automatic logic [8:0] ref_max(input logic [63:0] w, input logic [15:0] c);
        logic       v = 1'b0;
        logic [3:0] best = 4'h0;
        logic [3:0] idx = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (c[i] && (!v || w[i*4 +: 4] > best)) begin
                v = 1'b1;
                best = w[i*4 +: 4];
                idx = 4'(i);
            end
        end
        return {v, idx, best};
    endfunction

    // Drive away from the rising edge, then sample 1ns after it.
    task automatic apply(input logic [63:0] w, input logic [15:0] c);
        @(negedge clk_in);
        way_flatted_in = w;
        condition_in = c;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset;
        logic [8:0] got;
        reset_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        got = {select_valid_out, select_index_out, select_out};
        checks++;
        if (got !== 9'h000) begin
            errors++;
            $display("FAIL reset_initial got=%h exp=000", got);
        end
        @(negedge clk_in);
        reset_in = 1'b1;
        apply(64'h0000_0000_0900_0000, 16'hFFFF);
        got = {select_valid_out, select_index_out, select_out};
        checks++;
        if (got !== {1'b1, 4'd6, 4'h9}) begin
            errors++;
            $display("FAIL reset_pre_value got=%h exp=%h", got, {1'b1, 4'd6, 4'h9});
        end
        #2 reset_in = 1'b0;
        #1;
        got = {select_valid_out, select_index_out, select_out};
        checks++;
        if (got !== 9'h000) begin
            errors++;
            $display("FAIL reset_async got=%h exp=000", got);
        end
        @(posedge clk_in);
        #1;
        got = {select_valid_out, select_index_out, select_out};
        checks++;
        if (got !== 9'h000) begin
            errors++;
            $display("FAIL reset_held got=%h exp=000", got);
        end
        @(negedge clk_in);
        reset_in = 1'b1;
        #1;
        got = {select_valid_out, select_index_out, select_out};
        checks++;
        if (got !== 9'h000) begin
            errors++;
            $display("FAIL reset_release_before_edge got=%h exp=000", got);
        end
        @(posedge clk_in);
        #1;
        got = {select_valid_out, select_index_out, select_out};
        checks++;
        if (got !== {1'b1, 4'd6, 4'h9}) begin
            errors++;
            $display("FAIL reset_first_edge got=%h exp=%h", got, {1'b1, 4'd6, 4'h9});
        end
    endtask

    task automatic test_masked_max;
        apply(64'hABCD_5234_5234_ABA5, 16'b1110_0111_1110_0111);
        checks++;
        if ({select_valid_out, select_index_out, select_out} !== {1'b1, 4'd13, 4'hC}) begin
            errors++;
            $display("FAIL masked_max_a got=%b/%0d/%h exp=1/13/c",
                     select_valid_out, select_index_out, select_out);
        end
        apply(64'h587C_2934_2934_587A, 16'b1011_0111_1111_1111);
        checks++;
        if ({select_valid_out, select_index_out, select_out} !== {1'b1, 4'd12, 4'hC}) begin
            errors++;
            $display("FAIL masked_max_b got=%b/%0d/%h exp=1/12/c",
                     select_valid_out, select_index_out, select_out);
        end
        // Only a high way is disabled; the largest value there must not win.
        apply(64'hF000_0000_0000_0031, 16'h7FFF);
        checks++;
        if ({select_valid_out, select_index_out, select_out} !== {1'b1, 4'd1, 4'h3}) begin
            errors++;
            $display("FAIL masked_disabled_big got=%b/%0d/%h exp=1/1/3",
                     select_valid_out, select_index_out, select_out);
        end
    endtask

    task automatic test_tie;
        apply({16{4'h7}}, 16'hFFFF);
        checks++;
        if ({select_valid_out, select_index_out, select_out} !== {1'b1, 4'd0, 4'h7}) begin
            errors++;
            $display("FAIL tie_all got=%b/%0d/%h exp=1/0/7",
                     select_valid_out, select_index_out, select_out);
        end
        apply({16{4'h7}}, 16'hFFF0);
        checks++;
        if ({select_valid_out, select_index_out, select_out} !== {1'b1, 4'd4, 4'h7}) begin
            errors++;
            $display("FAIL tie_masked got=%b/%0d/%h exp=1/4/7",
                     select_valid_out, select_index_out, select_out);
        end
        // Tie split across the two halves of the tree.
        apply(64'h0E00_0000_0000_E000, 16'hFFFF);
        checks++;
        if ({select_valid_out, select_index_out, select_out} !== {1'b1, 4'd3, 4'hE}) begin
            errors++;
            $display("FAIL tie_halves got=%b/%0d/%h exp=1/3/e",
                     select_valid_out, select_index_out, select_out);
        end
    endtask

    task automatic test_empty_and_zero;
        apply(64'hFEDC_BA98_7654_3210, 16'h0000);
        checks++;
        if ({select_valid_out, select_index_out, select_out} !== 9'h000) begin
            errors++;
            $display("FAIL empty_mask got=%b/%0d/%h exp=0/0/0",
                     select_valid_out, select_index_out, select_out);
        end
        apply(64'hFFFF_FFFF_FFFF_FFFF, 16'h0000);
        checks++;
        if ({select_valid_out, select_index_out, select_out} !== 9'h000) begin
            errors++;
            $display("FAIL empty_mask_ff got=%b/%0d/%h exp=0/0/0",
                     select_valid_out, select_index_out, select_out);
        end
        apply(64'hFFFF_FFFF_FFFF_F0FF, 16'h0004);
        checks++;
        if ({select_valid_out, select_index_out, select_out} !== {1'b1, 4'd2, 4'h0}) begin
            errors++;
            $display("FAIL zero_value_valid got=%b/%0d/%h exp=1/2/0",
                     select_valid_out, select_index_out, select_out);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] w;
        logic [15:0] c;
        logic [8:0]  exp;
        logic [8:0]  prev_exp;
        prev_exp = {select_valid_out, select_index_out, select_out};
        for (int k = 0; k < 22; k++) begin
            w = {$urandom, $urandom};
            c = 16'($urandom);
            if (k == 20) begin
                w = 64'hFFFF_FFFF_FFFF_FFFF;
                c = 16'h8421;
            end else if (k == 21) begin
                w = 64'h0;
                c = 16'h1200;
            end
            exp = ref_max(w, c);
            @(negedge clk_in);
            // Before the edge the outputs still hold the previous vector's result.
            checks++;
            if ({select_valid_out, select_index_out, select_out} !== prev_exp) begin
                errors++;
                $display("FAIL stream_hold[%0d] got=%h exp=%h", k,
                         {select_valid_out, select_index_out, select_out}, prev_exp);
            end
            way_flatted_in = w;
            condition_in = c;
            @(posedge clk_in);
            #1;
            checks++;
            if ({select_valid_out, select_index_out, select_out} !== exp) begin
                errors++;
                $display("FAIL stream[%0d] w=%h c=%h got=%h exp=%h", k, w, c,
                         {select_valid_out, select_index_out, select_out}, exp);
            end
            prev_exp = exp;
        end
    endtask

    initial begin
        test_reset();
        test_masked_max();
        test_tie();
        test_empty_and_zero();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
